// File: rtl/lcd_bus_arbiter.sv
// HD44780-style LCD bus sequencer: optional power-up init, then round-robin
// two-port command arbitration with fixed-length EN slots. Macro: LCD_ARB_INIT_EN.
module lcd_bus_arbiter #(
   parameter int unsigned SLOT_CYCLES = 270000,
   parameter int unsigned EN_START    = 67499,
   parameter int unsigned EN_END      = 202499,
   parameter int unsigned INIT_SLOTS  = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic       rs0,
   input  logic       rs1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       busy,
   output logic       init_done,
   output logic       lcd_rs,
   output logic [7:0] lcd_data,
   output logic       lcd_rw,
   output logic       lcd_en
);

   typedef enum logic [1:0] {StInitWait, StInitCmd, StIdle, StXfer} state_e;

   localparam logic [31:0] LastCnt = 32'(SLOT_CYCLES - 1);

`ifdef LCD_ARB_INIT_EN
   localparam state_e ResetState = StInitWait;
   localparam logic   BusyReset  = 1'b1;

   logic [31:0] init_slot;
   logic [1:0]  cmd_idx;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h01;
         2'd2:    return 8'h0C;
         default: return 8'h06;
      endcase
   endfunction
`else
   localparam state_e ResetState = StIdle;
   localparam logic   BusyReset  = 1'b0;

   logic unused_init_slots;
   assign unused_init_slots = ^INIT_SLOTS;
   assign init_done = 1'b1;
`endif

   state_e      state;
   logic [31:0] slot_cnt;
   logic [31:0] cnt_inc;
   logic        is_last;
   logic        ptr;
   logic        gnt;
   logic        pick1;

   function automatic logic in_window(input logic [31:0] cnt);
      return (cnt >= EN_START) && (cnt <= EN_END);
   endfunction

   assign cnt_inc = slot_cnt + 32'd1;
   assign is_last = (slot_cnt == LastCnt);
   // A lone requester wins; on contention the pointer decides.
   assign pick1   = req1 & (~req0 | ptr);
   assign lcd_rw  = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ResetState;
         slot_cnt <= '0;
         ptr      <= 1'b0;
         gnt      <= 1'b0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         busy     <= BusyReset;
         lcd_en   <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_data <= 8'h00;
`ifdef LCD_ARB_INIT_EN
         init_slot <= '0;
         cmd_idx   <= '0;
         init_done <= 1'b0;
`endif
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
`ifdef LCD_ARB_INIT_EN
            StInitWait: begin
               lcd_en <= 1'b0;
               if (is_last) begin
                  slot_cnt <= '0;
                  if (init_slot == INIT_SLOTS - 1) begin
                     state     <= StInitCmd;
                     init_slot <= '0;
                     cmd_idx   <= '0;
                     lcd_rs    <= 1'b0;
                     lcd_data  <= init_cmd(2'd0);
                     lcd_en    <= in_window(32'd0);
                  end else begin
                     init_slot <= init_slot + 32'd1;
                  end
               end else begin
                  slot_cnt <= cnt_inc;
               end
            end
            StInitCmd: begin
               if (is_last) begin
                  slot_cnt <= '0;
                  if (cmd_idx == 2'd3) begin
                     state     <= StIdle;
                     busy      <= 1'b0;
                     init_done <= 1'b1;
                     lcd_en    <= 1'b0;
                  end else begin
                     cmd_idx  <= cmd_idx + 2'd1;
                     lcd_data <= init_cmd(cmd_idx + 2'd1);
                     lcd_en   <= in_window(32'd0);
                  end
               end else begin
                  slot_cnt <= cnt_inc;
                  lcd_en   <= in_window(cnt_inc);
               end
            end
`endif
            StXfer: begin
               if (is_last) begin
                  state    <= StIdle;
                  busy     <= 1'b0;
                  slot_cnt <= '0;
                  lcd_en   <= 1'b0;
               end else begin
                  slot_cnt <= cnt_inc;
                  lcd_en   <= in_window(cnt_inc);
                  // Ack is registered so it lands exactly on the last slot count.
                  if (cnt_inc == LastCnt) begin
                     ack0 <= ~gnt;
                     ack1 <= gnt;
                  end
               end
            end
            default: begin
               lcd_en <= 1'b0;
               if (req0 | req1) begin
                  gnt      <= pick1;
                  ptr      <= ~pick1;
                  lcd_rs   <= pick1 ? rs1 : rs0;
                  lcd_data <= pick1 ? data1 : data0;
                  state    <= StXfer;
                  slot_cnt <= '0;
                  busy     <= 1'b1;
                  lcd_en   <= in_window(32'd0);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with short slots; expectations follow
// LCD_ARB_INIT_EN so either build of the design can be exercised.
module tb_lcd_bus_arbiter;

   localparam int unsigned SlotCycles = 20;
   localparam int unsigned EnStart    = 5;
   localparam int unsigned EnEnd      = 14;
   localparam int unsigned InitSlots  = 3;

`ifdef LCD_ARB_INIT_EN
   localparam logic BusyRst = 1'b1;
   localparam logic DoneRst = 1'b0;
`else
   localparam logic BusyRst = 1'b0;
   localparam logic DoneRst = 1'b1;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1, rs0, rs1;
   logic [7:0] data0, data1;
   logic       ack0, ack1, busy, init_done, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rise_cyc = 0;
   int prev_rise;
   logic       last_rs;
   logic [7:0] last_data;
   logic [7:0] cmds [4];

   always #5 clk = ~clk;

   lcd_bus_arbiter #(
      .SLOT_CYCLES(SlotCycles),
      .EN_START   (EnStart),
      .EN_END     (EnEnd),
      .INIT_SLOTS (InitSlots)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req0     (req0),
      .req1     (req1),
      .rs0      (rs0),
      .rs1      (rs1),
      .data0    (data0),
      .data1    (data1),
      .ack0     (ack0),
      .ack1     (ack1),
      .busy     (busy),
      .init_done(init_done),
      .lcd_rs   (lcd_rs),
      .lcd_data (lcd_data),
      .lcd_rw   (lcd_rw),
      .lcd_en   (lcd_en)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Checks outputs right after the first reset edge, then releases reset.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      step();
      check({tag, "_en"}, lcd_en, 1'b0);
      check({tag, "_ack0"}, ack0, 1'b0);
      check({tag, "_ack1"}, ack1, 1'b0);
      check({tag, "_rs"}, lcd_rs, 1'b0);
      check({tag, "_data"}, lcd_data, 8'h00);
      check({tag, "_rw"}, lcd_rw, 1'b0);
      check({tag, "_busy"}, busy, BusyRst);
      check({tag, "_done"}, init_done, DoneRst);
      step();
      reset = 1'b0;
      cyc = 0;
      last_rs = 1'b0;
      last_data = 8'h00;
   endtask

   // Starts in an IDLE cycle with a request pending; ends on the slot's last count.
   task automatic run_slot(input logic exp_port, input logic exp_rs, input logic [7:0] exp_data,
                           input logic drop, input string tag);
      int en_cnt, own_acks, other_acks;
      en_cnt = 0;
      own_acks = 0;
      other_acks = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (lcd_en) begin
            if (en_cnt == 0) rise_cyc = cyc;
            en_cnt++;
         end
         if ((exp_port ? ack1 : ack0) === 1'b1) own_acks++;
         if ((exp_port ? ack0 : ack1) === 1'b1) other_acks++;
         if (k == 0) begin
            check({tag, "_rs_k0"}, lcd_rs, exp_rs);
            check({tag, "_data_k0"}, lcd_data, exp_data);
            check({tag, "_busy"}, busy, 1'b1);
         end
         if (k == 4)  check({tag, "_en_k4"}, lcd_en, 1'b0);
         if (k == 5)  check({tag, "_en_k5"}, lcd_en, 1'b1);
         if (k == 14) check({tag, "_en_k14"}, lcd_en, 1'b1);
         if (k == 15) check({tag, "_en_k15"}, lcd_en, 1'b0);
         if (k == 19) begin
            check({tag, "_ack_k19"}, exp_port ? ack1 : ack0, 1'b1);
            check({tag, "_rs_k19"}, lcd_rs, exp_rs);
            check({tag, "_data_k19"}, lcd_data, exp_data);
            if (drop) begin
               req0 = 1'b0;
               req1 = 1'b0;
            end
         end
      end
      check({tag, "_en_len"}, en_cnt, 10);
      check({tag, "_own_acks"}, own_acks, 1);
      check({tag, "_other_acks"}, other_acks, 0);
      last_rs = exp_rs;
      last_data = exp_data;
   endtask

   task automatic idle_step(input string tag);
      step();
      check({tag, "_idle_busy"}, busy, 1'b0);
      check({tag, "_idle_en"}, lcd_en, 1'b0);
      check({tag, "_idle_acks"}, {ack1, ack0}, 2'b00);
      check({tag, "_idle_hold"}, {lcd_rs, lcd_data}, {last_rs, last_data});
   endtask

`ifdef LCD_ARB_INIT_EN
   // Runs cycles 1..140 after reset release; requests must be ignored throughout.
   task automatic run_init(input string tag, input bit late_req1);
      int en_wait, acks, s, k;
      en_wait = 0;
      acks = 0;
      for (int c = 1; c <= 140; c++) begin
         step();
         if (late_req1 && c == 10) begin
            req1 = 1'b1;
            rs1 = 1'b0;
            data1 = 8'h33;
         end
         if (ack0 === 1'b1 || ack1 === 1'b1) acks++;
         if (c < 60 && lcd_en !== 1'b0) en_wait++;
         if (c == 59) check({tag, "_wait_data"}, lcd_data, 8'h00);
         if (c >= 60 && c < 140) begin
            s = (c - 60) / 20;
            k = (c - 60) % 20;
            if (k == 0) begin
               check({tag, "_cmd_data"}, lcd_data, cmds[s]);
               check({tag, "_cmd_rs"}, lcd_rs, 1'b0);
            end
            if (k == 4)  check({tag, "_cmd_en_k4"}, lcd_en, 1'b0);
            if (k == 5)  check({tag, "_cmd_en_k5"}, lcd_en, 1'b1);
            if (k == 14) check({tag, "_cmd_en_k14"}, lcd_en, 1'b1);
            if (k == 15) check({tag, "_cmd_en_k15"}, lcd_en, 1'b0);
            if (k == 19) check({tag, "_cmd_data_end"}, lcd_data, cmds[s]);
         end
         if (c == 139) begin
            check({tag, "_done_139"}, init_done, 1'b0);
            check({tag, "_busy_139"}, busy, 1'b1);
         end
         if (c == 140) begin
            check({tag, "_done_140"}, init_done, 1'b1);
            check({tag, "_busy_140"}, busy, 1'b0);
            check({tag, "_en_140"}, lcd_en, 1'b0);
            check({tag, "_data_140"}, lcd_data, 8'h06);
         end
      end
      check({tag, "_wait_en"}, en_wait, 0);
      check({tag, "_acks"}, acks, 0);
      last_rs = 1'b0;
      last_data = 8'h06;
   endtask
`endif

   initial begin
      cmds[0] = 8'h38;
      cmds[1] = 8'h01;
      cmds[2] = 8'h0C;
      cmds[3] = 8'h06;
      reset = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      rs0 = 1'b0;
      rs1 = 1'b0;
      data0 = 8'h00;
      data1 = 8'h00;

`ifdef LCD_ARB_INIT_EN
      do_reset("rst");
      run_init("init", 1'b0);
`else
      req1 = 1'b1;
      rs1 = 1'b1;
      data1 = 8'h5A;
      do_reset("rst");
      run_slot(1'b1, 1'b1, 8'h5A, 1'b1, "first_req1");
      idle_step("first_req1");
`endif

      // Single requester, then single requester against the pointer.
      req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
      run_slot(1'b0, 1'b1, 8'h41, 1'b1, "req0");
      idle_step("req0");
      req0 = 1'b1; rs0 = 1'b0; data0 = 8'h02;
      run_slot(1'b0, 1'b0, 8'h02, 1'b1, "req0_vs_ptr");
      idle_step("req0_vs_ptr");
      req1 = 1'b1; rs1 = 1'b1; data1 = 8'h7E;
      run_slot(1'b1, 1'b1, 8'h7E, 1'b1, "req1");
      idle_step("req1");

      // Both held high: grants alternate 0,1,0,1 at 21-cycle spacing.
      req0 = 1'b1; rs0 = 1'b0; data0 = 8'h80;
      req1 = 1'b1; rs1 = 1'b1; data1 = 8'h55;
      run_slot(1'b0, 1'b0, 8'h80, 1'b0, "rr_a");
      prev_rise = rise_cyc;
      idle_step("rr_a");
      run_slot(1'b1, 1'b1, 8'h55, 1'b0, "rr_b");
      check("rr_spacing_ab", rise_cyc - prev_rise, 21);
      prev_rise = rise_cyc;
      idle_step("rr_b");
      run_slot(1'b0, 1'b0, 8'h80, 1'b0, "rr_c");
      check("rr_spacing_bc", rise_cyc - prev_rise, 21);
      prev_rise = rise_cyc;
      idle_step("rr_c");
      run_slot(1'b1, 1'b1, 8'h55, 1'b1, "rr_d");
      check("rr_spacing_cd", rise_cyc - prev_rise, 21);
      idle_step("rr_d");

      // Reset at slot count 8 of a port-0 transfer (pointer then favours port 1).
      req0 = 1'b1; rs0 = 1'b1; data0 = 8'hC3;
      for (int k = 0; k <= 8; k++) step();
      check("pre_reset_en", lcd_en, 1'b1);
      req1 = 1'b1; rs1 = 1'b0; data1 = 8'h5A;
      do_reset("mid_xfer");
`ifdef LCD_ARB_INIT_EN
      run_init("reinit", 1'b0);
`endif
      run_slot(1'b0, 1'b1, 8'hC3, 1'b1, "ptr_reset");
      idle_step("ptr_reset");

`ifdef LCD_ARB_INIT_EN
      // Request raised during INIT_WAIT is held off until the first IDLE cycle.
      do_reset("rst_late");
      run_init("late_req1", 1'b1);
      run_slot(1'b1, 1'b0, 8'h33, 1'b1, "late_req1");
      check("late_req1_ack_cycle", cyc, 160);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
